writeback: RTL and testbench
============================

# writeback

Final pipeline stage of the RISC-V core: accepts one retiring instruction per handshake from the memory stage, waits for the data-memory response on loads, formats load data, and produces the register-file write port (`reg_write`, `wr_idx`, `wr_data`) that feeds the decode stage's register file. It is the writer end of the register-file interface that decode reads. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 32, retired-counter width.

Ports:
- `clk`  in  1  core clock. Single clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  writeback can accept. Combinational: `state != WAIT`.
- `in_reg_write`  in  1  instruction writes rd.
- `in_rd`  in  5  destination index.
- `in_wb_sel`  in  2  result source: 00 ALU, 01 MEM (load), 10 PC+4, 11 reserved (treated as ALU).
- `in_funct3`  in  3  load size/sign.
- `in_alu`  in  XLEN  ALU result; `in_alu[1:0]` is the load byte offset.
- `in_pc4`  in  XLEN  PC+4.
- `mem_rvalid`  in  1  data-memory read response valid.
- `mem_rdata`  in  XLEN  raw aligned word from data memory.
- `reg_write`  out  1  register-file write enable.
- `wr_idx`  out  5  register-file write index.
- `wr_data`  out  XLEN  register-file write data.
- `retired`  out  CNT_W  count of retired instructions.
- `resp_err`  out  1  sticky: `mem_rvalid` arrived while not in WAIT.

## Operation
- The handshake is accepted when `in_valid & in_ready`.
- FSM states:
  - IDLE.
    - Accept of a non-load: register the result; `reg_write` is high the next cycle; stay IDLE.
    - Accept of a load (`in_wb_sel==01`): latch rd, funct3, offset and reg_write, then go to WAIT.
  - WAIT.
    - `in_ready=0`.
    - On `mem_rvalid`, format the data; `reg_write` is high the next cycle; go to IDLE.
- `reg_write` is forced to 0 when `in_reg_write==0` or `rd==0`. The instruction still counts as retired.
- `retired` increments by 1 in the cycle the write-port outputs update for an instruction: non-load accept, or load response. It wraps modulo 2^CNT_W.
- Load formatting uses offset `off=in_alu[1:0]`:
  - LB 000: sign-extend byte `off`.
  - LBU 100: zero-extend byte `off`.
  - LH 001: sign-extend halfword `in_alu[1]`. `off[0]` is ignored.
  - LHU 101: zero-extend halfword `in_alu[1]`.
  - LW 010, and 011/110/111: full word. Offset is ignored.
- When `reg_write=0`, `wr_idx` and `wr_data` hold their last values.
- `mem_rvalid` in IDLE:
  - It is ignored for data purposes.
  - It sets `resp_err`. Only `rst` clears `resp_err`.

## Timing
- Reset: the FSM goes to IDLE. `reg_write=0`, `wr_idx=0`, `wr_data=0`, `retired=0`, `resp_err=0`. `in_ready=1` in the cycle after reset is released.
- Non-load latency: accept in cycle N → `reg_write`/`wr_idx`/`wr_data` valid in cycle N+1 for exactly one cycle. Back-to-back accepts give consecutive write cycles.
- Load latency:
  - Accept in cycle N → WAIT from N+1.
  - The earliest response is at N+1. A `mem_rvalid` in cycle N is not part of this load.
  - Response sampled in cycle M → write in M+1, `in_ready=1` in M+1, and a new accept is possible in M+1.
- `mem_rvalid` and `in_valid` high together in WAIT: only the response is consumed. The instruction waits.
- `rst` in WAIT: the pending load is dropped and no write occurs. A later `mem_rvalid` sets `resp_err`.
- `rst` has priority over all other events in the same cycle.
- All outputs except `in_ready` are registered.

## Structure
- Shared package `riscv_pkg` holds:
  - the `wb_sel` encodings (`WB_ALU`, `WB_MEM`, `WB_PC4`);
  - the load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`);
  - the writeback state enum (`WB_IDLE`, `WB_WAIT`).
- One sub-module, `load_align`. It is combinational and maps (funct3, offset, rdata) to XLEN data, so it can be unit-tested separately.

## Test plan
- Reset, then ALU op with rd=5, alu=0x0000_1234, wb_sel=00 → cycle after accept: `reg_write=1`, `wr_idx=5`, `wr_data=0x0000_1234`, `retired=1`.
- LB with offset 3, rdata=0x80AA_BBCC, response 3 cycles after accept → `in_ready=0` for 3 cycles, then `wr_data=0xFFFF_FF80`. LBU with the same inputs → `0x0000_0080`. LHU with offset 2 → `0x0000_80AA`.
- Three back-to-back ALU ops to rd=1,2,3 → three consecutive write cycles, `retired=3`.
- ALU op with rd=0 and reg_write=1 → `reg_write` stays 0, `retired` increments.
- `mem_rvalid` pulse in IDLE → `resp_err=1`, no write. It stays 1 until `rst`.
- Load accepted, then `rst` asserted in WAIT, then `mem_rvalid` → no write, `retired=0`, `resp_err=1`. Also preload `retired=0xFFFF_FFFF` via 2^32−1 retires (or force) → the next retire gives 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core definitions.
//   - wb_sel encodings that pick the writeback result source
//   - load funct3 constants that pick load size and sign
//   - writeback FSM state enum
package riscv_pkg;

   // Result source for the register-file write. Code 2'b11 is reserved and
   // treated like WB_ALU.
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // Load funct3 codes. The remaining codes (011, 110, 111) load a full word.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_load_align.sv
// load_align: combinational load-data formatter.
// It selects a byte, halfword or word from an aligned memory word and then
// sign-extends or zero-extends the result to XLEN.
//   funct3  in  3     load size/sign
//   off     in  2     byte offset within the word
//   rdata   in  XLEN  raw aligned word from data memory
//   data    out XLEN  formatted load result
module load_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = rdata[8*gi +: 8];
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = rdata[16*gi +: 16];
   end

   // The halfword selection uses only off[1]. Misaligned halfwords are not
   // split across lanes.
   assign byte_sel = byte_lane[off];
   assign half_sel = half_lane[off[1]];

   always_comb begin
      data = rdata;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage.
// It accepts one retiring instruction per handshake. For loads it waits for
// the data-memory response. It then drives the register-file write port and
// counts retired instructions.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    handshake from the memory stage (in_ready is combinational)
//   in_reg_write, in_rd  write enable and destination register
//   in_wb_sel            result source (ALU / MEM / PC+4, 11 treated as ALU)
//   in_funct3, in_alu    load size/sign; ALU result, whose [1:0] is the load offset
//   in_pc4               PC+4
//   mem_rvalid/mem_rdata data-memory read response
//   reg_write, wr_idx, wr_data  register-file write port (registered)
//   retired              retired-instruction counter (wraps)
//   resp_err             sticky flag: a response arrived while no load was pending
module writeback
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_reg_write,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_wb_sel,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_alu,
   input  logic [XLEN-1:0]  in_pc4,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             reg_write,
   output logic [4:0]       wr_idx,
   output logic [XLEN-1:0]  wr_data,
   output logic [CNT_W-1:0] retired,
   output logic             resp_err
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   wb_state_t        state_reg;
   logic [4:0]       ld_rd_reg;
   logic [2:0]       ld_f3_reg;
   logic [1:0]       ld_off_reg;
   logic             ld_we_reg;

   logic             reg_write_reg;
   logic [4:0]       wr_idx_reg;
   logic [XLEN-1:0]  wr_data_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             resp_err_reg;

   logic             accept;
   logic             is_load;
   logic             direct_we;
   logic [XLEN-1:0]  direct_data;
   logic [XLEN-1:0]  ld_data;

   assign in_ready    = (state_reg != WB_WAIT);
   assign accept      = in_valid & in_ready;
   assign is_load     = (in_wb_sel == WB_MEM);
   // A write to x0 is suppressed, but the instruction still retires.
   assign direct_we   = in_reg_write & (in_rd != 5'd0);
   assign direct_data = (in_wb_sel == WB_PC4) ? in_pc4 : in_alu;

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3 (ld_f3_reg),
      .off    (ld_off_reg),
      .rdata  (mem_rdata),
      .data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= WB_IDLE;
         ld_rd_reg     <= '0;
         ld_f3_reg     <= '0;
         ld_off_reg    <= '0;
         ld_we_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         wr_idx_reg    <= '0;
         wr_data_reg   <= '0;
         retired_reg   <= '0;
         resp_err_reg  <= 1'b0;
      end else begin
         reg_write_reg <= 1'b0;
         case (state_reg)
            WB_IDLE: begin
               // No load is outstanding, so any response here is stray.
               if (mem_rvalid) begin
                  resp_err_reg <= 1'b1;
               end
               if (accept) begin
                  if (is_load) begin
                     ld_rd_reg  <= in_rd;
                     ld_f3_reg  <= in_funct3;
                     ld_off_reg <= in_alu[1:0];
                     ld_we_reg  <= direct_we;
                     state_reg  <= WB_WAIT;
                  end else begin
                     reg_write_reg <= direct_we;
                     if (direct_we) begin
                        wr_idx_reg  <= in_rd;
                        wr_data_reg <= direct_data;
                     end
                     retired_reg <= retired_reg + CNT_ONE;
                  end
               end
            end
            WB_WAIT: begin
               if (mem_rvalid) begin
                  reg_write_reg <= ld_we_reg;
                  if (ld_we_reg) begin
                     wr_idx_reg  <= ld_rd_reg;
                     wr_data_reg <= ld_data;
                  end
                  retired_reg <= retired_reg + CNT_ONE;
                  state_reg   <= WB_IDLE;
               end
            end
            default: state_reg <= WB_IDLE;
         endcase
      end
   end

   assign reg_write = reg_write_reg;
   assign wr_idx    = wr_idx_reg;
   assign wr_data   = wr_data_reg;
   assign retired   = retired_reg;
   assign resp_err  = resp_err_reg;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_reg_write = 1'b0;
   logic [4:0]  in_rd = '0;
   logic [1:0]  in_wb_sel = '0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_alu = '0;
   logic [31:0] in_pc4 = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        reg_write;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic [31:0] retired;
   logic        resp_err;

   // Narrow-counter copy that shares every input, so counter wrap is observable.
   logic        s_in_ready;
   logic        s_reg_write;
   logic [4:0]  s_wr_idx;
   logic [31:0] s_wr_data;
   logic [2:0]  s_retired;
   logic        s_resp_err;

   always #5 clk = ~clk;

   writeback #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
      .in_funct3(in_funct3), .in_alu(in_alu), .in_pc4(in_pc4),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_write(reg_write), .wr_idx(wr_idx), .wr_data(wr_data),
      .retired(retired), .resp_err(resp_err)
   );

   writeback #(.XLEN(32), .CNT_W(3)) dut_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
      .in_funct3(in_funct3), .in_alu(in_alu), .in_pc4(in_pc4),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_write(s_reg_write), .wr_idx(s_wr_idx), .wr_data(s_wr_data),
      .retired(s_retired), .resp_err(s_resp_err)
   );

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_ret = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ret(input string name);
      chk({name, "_retired"}, {32'd0, retired}, {32'd0, exp_ret});
      chk({name, "_retired_w3"}, {61'd0, s_retired}, {61'd0, exp_ret[2:0]});
   endtask

   // Present one instruction for exactly one accepting edge; in_valid stays high.
   task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
      in_valid     = 1'b1;
      in_reg_write = we;
      in_rd        = rd;
      in_wb_sel    = sel;
      in_funct3    = f3;
      in_alu       = alu;
      in_pc4       = pc4;
   endtask

   task automatic direct_op(input string name, input logic we, input logic [4:0] rd,
                            input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc4);
      chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
      drive(we, rd, sel, F3_LW, alu, pc4);
      if (we && rd != 5'd0) exp_q.push_back('{idx: rd, data: (sel == WB_PC4) ? pc4 : alu});
      exp_ret++;
      @(posedge clk); #1;
   endtask

   task automatic load_op(input string name, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rdata, input int delay,
                          input logic [31:0] exp_data);
      chk({name, "_ready_idle"}, {63'd0, in_ready}, 64'd1);
      drive(1'b1, rd, WB_MEM, f3, alu, 32'h0);
      exp_q.push_back('{idx: rd, data: exp_data});
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < delay; i++) begin
         chk({name, "_ready_wait"}, {63'd0, in_ready}, 64'd0);
         if (i == delay - 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
         end
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      exp_ret++;
      chk({name, "_ready_after"}, {63'd0, in_ready}, 64'd1);
      chk_ret(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      wr_t got;
      wr_t want;

      // Monitor: pops the scoreboard whenever the write port fires.
      fork
         forever begin
            @(negedge clk);
            if (!rst && reg_write) begin
               got = '{idx: wr_idx, data: wr_data};
               $display("wr idx=%0d data=%08h retired=%0d", wr_idx, wr_data, retired);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_write: got idx=%0d data=%08h expected no write",
                           wr_idx, wr_data);
               end else begin
                  want = exp_q.pop_front();
                  chk("wr_idx", {59'd0, got.idx}, {59'd0, want.idx});
                  chk("wr_data", {32'd0, got.data}, {32'd0, want.data});
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
      chk("rst_wr_idx", {59'd0, wr_idx}, 64'd0);
      chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
      chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk_ret("rst");

      // Single ALU op.
      direct_op("alu5", 1'b1, 5'd5, WB_ALU, 32'h0000_1234, 32'h0);
      in_valid = 1'b0;
      chk_ret("alu5");

      // Load formatting.
      load_op("lb",  5'd10, F3_LB,  32'h0000_1003, 32'h80AA_BBCC, 3, 32'hFFFF_FF80);
      load_op("lbu", 5'd11, F3_LBU, 32'h0000_1003, 32'h80AA_BBCC, 3, 32'h0000_0080);
      load_op("lhu", 5'd12, F3_LHU, 32'h0000_1002, 32'h80AA_BBCC, 2, 32'h0000_80AA);
      load_op("lh",  5'd13, F3_LH,  32'h0000_1001, 32'h80AA_BBCC, 1, 32'hFFFF_BBCC);
      load_op("lw",  5'd14, F3_LW,  32'h0000_1003, 32'h80AA_BBCC, 2, 32'h80AA_BBCC);
      load_op("lb1", 5'd15, F3_LB,  32'h0000_1001, 32'h1234_5678, 1, 32'h0000_0056);

      // Three back-to-back ALU ops.
      direct_op("b2b1", 1'b1, 5'd1, WB_ALU, 32'h0000_0011, 32'h0);
      direct_op("b2b2", 1'b1, 5'd2, WB_ALU, 32'h0000_0022, 32'h0);
      direct_op("b2b3", 1'b1, 5'd3, WB_ALU, 32'h0000_0033, 32'h0);
      in_valid = 1'b0;
      chk_ret("b2b");

      // Write to x0 retires without writing.
      direct_op("rd0", 1'b1, 5'd0, WB_ALU, 32'hDEAD_BEEF, 32'h0);
      in_valid = 1'b0;
      chk("rd0_reg_write", {63'd0, reg_write}, 64'd0);
      chk_ret("rd0");

      // PC+4 source, and the reserved sel code 11 behaving as ALU.
      direct_op("pc4", 1'b1, 5'd4, WB_PC4, 32'h1111_1111, 32'h0000_2004);
      direct_op("sel3", 1'b1, 5'd6, 2'b11, 32'h0000_ABCD, 32'h0000_3008);
      in_valid = 1'b0;
      chk_ret("pc4");

      // A stray response in IDLE sets the sticky error and writes nothing.
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("stray_resp_err", {63'd0, resp_err}, 64'd1);
      chk("stray_reg_write", {63'd0, reg_write}, 64'd0);
      direct_op("sticky", 1'b1, 5'd7, WB_ALU, 32'h0000_0077, 32'h0);
      in_valid = 1'b0;
      chk("sticky_resp_err", {63'd0, resp_err}, 64'd1);

      // Response and a new instruction together in WAIT: the response is
      // consumed first and the instruction is accepted on the next edge.
      drive(1'b1, 5'd20, WB_MEM, F3_LW, 32'h0, 32'h0);
      exp_q.push_back('{idx: 5'd20, data: 32'hCAFE_F00D});
      @(posedge clk); #1;
      drive(1'b1, 5'd21, WB_ALU, F3_LW, 32'h0000_5555, 32'h0);
      exp_q.push_back('{idx: 5'd21, data: 32'h0000_5555});
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      chk("both_ready_wait", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      exp_ret++;
      chk("both_ready_after", {63'd0, in_ready}, 64'd1);
      chk_ret("both_ld");
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_ret++;
      chk_ret("both_alu");

      // Reset during WAIT drops the load; a later response is stray.
      drive(1'b1, 5'd22, WB_MEM, F3_LW, 32'h0, 32'h0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rstw_ready_wait", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ret = '0;
      chk("rstw_ready", {63'd0, in_ready}, 64'd1);
      chk("rstw_resp_err_clr", {63'd0, resp_err}, 64'd0);
      chk_ret("rstw");
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1357_9BDF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("rstw_resp_err", {63'd0, resp_err}, 64'd1);
      chk("rstw_reg_write", {63'd0, reg_write}, 64'd0);
      chk_ret("rstw_late");

      // Nine retires: the 3-bit counter wraps through 0.
      for (int i = 1; i <= 9; i++) begin
         direct_op("wrap", 1'b1, 5'(i), WB_ALU, 32'(i * 32'h101), 32'h0);
      end
      in_valid = 1'b0;
      chk_ret("wrap");

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
